// File: rtl/lwc_seg_source_pkg.sv
// Shared constants and state encoding for the LWC segment source.
package lwc_seg_source_pkg;

    localparam int LWC_BUSW  = 32;
    localparam int LWC_DEPTH = 64;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_STRM = 2'd1,
        S_DONE = 2'd2
    } seg_state_e;

    function automatic int bytes_per_word(input int busw);
        return busw / 8;
    endfunction

endpackage

// File: rtl/lwc_seg_source_if.sv
// Valid/ready word port feeding the LWC pdi_* or sdi_* inputs.
interface lwc_seg_source_if #(
    parameter int BUSW = 32
);
    logic [BUSW-1:0] data;
    logic            valid;
    logic            ready;
    logic            last;

    modport master (output data, output valid, output last, input ready);
    modport slave  (input data, input valid, input last, output ready);
endinterface

// File: rtl/lwc_seg_source_byte_ram.sv
// DEPTH x 8 segment storage: one write port, BUSW/8 combinational read taps at rd_base onward.
module lwc_seg_source_byte_ram #(
    parameter int BUSW  = 32,
    parameter int DEPTH = 64,
    parameter int CNTW  = 7
) (
    input  logic            clk,
    input  logic            wr_en,
    input  logic [CNTW-1:0] wr_addr,
    input  logic [7:0]      wr_byte,
    input  logic [CNTW-1:0] rd_base,
    output logic [BUSW-1:0] rd_word
);
    localparam int NB = BUSW / 8;
    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [CNTW:0] DEPTH_X = (CNTW+1)'(DEPTH);

    logic [7:0] mem_r [DEPTH];

    // Byte write; addresses beyond the array are never produced by the owner but are guarded anyway.
    always_ff @(posedge clk) begin
        if (wr_en && ({1'b0, wr_addr} < DEPTH_X)) begin
            mem_r[wr_addr[AW-1:0]] <= wr_byte;
        end
    end

    for (genvar k = 0; k < NB; k++) begin : g_tap
        logic [CNTW:0] addr_s;
        assign addr_s = {1'b0, rd_base} + (CNTW+1)'(k);
        assign rd_word[BUSW-1-8*k -: 8] = (addr_s < DEPTH_X) ? mem_r[addr_s[AW-1:0]] : 8'h00;
    end

endmodule

// File: rtl/lwc_seg_source.sv
// Segment source: loads a byte stream, then replays it as zero-padded BUSW-wide words
// with last-word flag, backpressure, rewind, flush and sticky overflow.
module lwc_seg_source
    import lwc_seg_source_pkg::*;
#(
    parameter int BUSW  = LWC_BUSW,
    parameter int DEPTH = LWC_DEPTH,
    parameter int CNTW  = $clog2(DEPTH + 1)
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                wr_en,
    input  logic [7:0]          wr_byte,
    output logic                wr_full,
    output logic                overflow,
    input  logic                commit,
    input  logic                rewind,
    input  logic                flush,
    lwc_seg_source_if.master    out_if,
    output logic                busy,
    output logic [CNTW-1:0]     bytes_left
);
    localparam int              NB      = bytes_per_word(BUSW);
    localparam logic [CNTW-1:0] NB_C    = CNTW'(NB);
    localparam logic [CNTW-1:0] DEPTH_C = CNTW'(DEPTH);

    seg_state_e      state_r;
    seg_state_e      state_nx_s;
    logic [CNTW-1:0] count_r;
    logic [CNTW-1:0] rp_r;
    logic            overflow_r;

    logic            valid_s;
    logic            beat_s;
    logic            last_s;
    logic            wr_ok_s;
    logic            wr_drop_s;
    logic            start_s;
    logic [CNTW-1:0] remain_s;
    logic [BUSW-1:0] ram_word_s;
    logic [NB-1:0]   in_seg_s;

    assign valid_s   = (state_r == S_STRM);
    assign beat_s    = valid_s && out_if.ready;
    assign remain_s  = count_r - rp_r;
    assign last_s    = (remain_s <= NB_C);
    // Loading only happens in idle; flush takes priority over a write or commit in the same cycle.
    assign wr_ok_s   = (state_r == S_IDLE) && wr_en && !flush && (count_r != DEPTH_C);
    assign wr_drop_s = (state_r == S_IDLE) && wr_en && !flush && (count_r == DEPTH_C);
    assign start_s   = (state_r == S_IDLE) && commit && !flush &&
                       ((count_r != {CNTW{1'b0}}) || wr_ok_s);

    for (genvar k = 0; k < NB; k++) begin : g_seg
        assign in_seg_s[k] = (({1'b0, rp_r} + (CNTW+1)'(k)) < {1'b0, count_r});
    end

    lwc_seg_source_byte_ram #(
        .BUSW  (BUSW),
        .DEPTH (DEPTH),
        .CNTW  (CNTW)
    ) u_ram (
        .clk     (clk),
        .wr_en   (wr_ok_s),
        .wr_addr (count_r),
        .wr_byte (wr_byte),
        .rd_base (rp_r),
        .rd_word (ram_word_s)
    );

    // State register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_r <= S_IDLE;
        end else begin
            state_r <= state_nx_s;
        end
    end

    // Next-state decode.
    always_comb begin
        state_nx_s = state_r;
        case (state_r)
            S_IDLE: begin
                if (start_s) state_nx_s = S_STRM;
                else         state_nx_s = S_IDLE;
            end
            S_STRM: begin
                if (flush)                 state_nx_s = S_IDLE;
                else if (beat_s && last_s) state_nx_s = S_DONE;
                else                       state_nx_s = S_STRM;
            end
            S_DONE: begin
                if (flush)       state_nx_s = S_IDLE;
                else if (rewind) state_nx_s = S_STRM;
                else             state_nx_s = S_DONE;
            end
            default: state_nx_s = S_IDLE;
        endcase
    end

    // Byte count, read pointer and sticky overflow.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            count_r    <= {CNTW{1'b0}};
            rp_r       <= {CNTW{1'b0}};
            overflow_r <= 1'b0;
        end else if (flush) begin
            count_r    <= {CNTW{1'b0}};
            rp_r       <= {CNTW{1'b0}};
            overflow_r <= 1'b0;
        end else begin
            case (state_r)
                S_IDLE: begin
                    if (wr_ok_s)   count_r    <= count_r + {{(CNTW-1){1'b0}}, 1'b1};
                    if (wr_drop_s) overflow_r <= 1'b1;
                    if (start_s)   rp_r       <= {CNTW{1'b0}};
                end
                S_STRM: begin
                    if (beat_s) rp_r <= rp_r + NB_C;
                end
                S_DONE: begin
                    if (rewind) rp_r <= {CNTW{1'b0}};
                end
                default: begin
                    rp_r <= {CNTW{1'b0}};
                end
            endcase
        end
    end

    // Outputs decoded from registered state; bytes past the segment end read as zero padding.
    always_comb begin
        out_if.data  = {BUSW{1'b0}};
        out_if.valid = valid_s;
        out_if.last  = valid_s && last_s;
        busy         = (state_r != S_IDLE);
        wr_full      = (count_r == DEPTH_C);
        overflow     = overflow_r;
        if (valid_s) bytes_left = remain_s;
        else         bytes_left = {CNTW{1'b0}};
        for (int k = 0; k < NB; k++) begin
            if (valid_s && in_seg_s[k]) out_if.data[BUSW-1-8*k -: 8] = ram_word_s[BUSW-1-8*k -: 8];
            else                        out_if.data[BUSW-1-8*k -: 8] = 8'h00;
        end
    end

endmodule

// File: tb/tb_lwc_seg_source.sv
// Scoreboard bench: a 32-bit and an 8-bit segment source share one stimulus stream.
module tb_lwc_seg_source;

    typedef struct {
        logic [31:0] data;
        logic        last;
        int          bleft;
    } exp_t;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       wr_en = 1'b0;
    logic [7:0] wr_byte = 8'h00;
    logic       commit = 1'b0;
    logic       rewind = 1'b0;
    logic       flush = 1'b0;
    logic       ready = 1'b0;

    logic       a_full, a_ovf, a_busy;
    logic [6:0] a_bleft;
    logic       b_full, b_ovf, b_busy;
    logic [6:0] b_bleft;

    int         n_checks = 0;
    int         n_errors = 0;
    logic [7:0] mdl[$];
    exp_t       sb_a[$];
    exp_t       sb_b[$];

    lwc_seg_source_if #(.BUSW(32)) if_a ();
    lwc_seg_source_if #(.BUSW(8))  if_b ();
    assign if_a.ready = ready;
    assign if_b.ready = ready;

    lwc_seg_source #(.BUSW(32), .DEPTH(64)) u_dut_a (
        .clk(clk), .rst(rst), .wr_en(wr_en), .wr_byte(wr_byte), .wr_full(a_full),
        .overflow(a_ovf), .commit(commit), .rewind(rewind), .flush(flush),
        .out_if(if_a), .busy(a_busy), .bytes_left(a_bleft)
    );

    lwc_seg_source #(.BUSW(8), .DEPTH(64)) u_dut_b (
        .clk(clk), .rst(rst), .wr_en(wr_en), .wr_byte(wr_byte), .wr_full(b_full),
        .overflow(b_ovf), .commit(commit), .rewind(rewind), .flush(flush),
        .out_if(if_b), .busy(b_busy), .bytes_left(b_bleft)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic exp_t build_word(input int bpw, input int w);
        exp_t e;
        int   n = mdl.size();
        e.data = 32'h0;
        for (int k = 0; k < bpw; k++) begin
            e.data = {e.data[23:0], ((w*bpw + k) < n) ? mdl[w*bpw + k] : 8'h00};
        end
        e.last  = ((w + 1) * bpw >= n);
        e.bleft = n - w * bpw;
        return e;
    endfunction

    task automatic push_expected();
        for (int w = 0; w * 4 < mdl.size(); w++) sb_a.push_back(build_word(4, w));
        for (int w = 0; w < mdl.size(); w++)     sb_b.push_back(build_word(1, w));
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic load_bytes(input int n, input int base);
        for (int i = 0; i < n; i++) begin
            wr_en   = 1'b1;
            wr_byte = 8'(base + i);
            if (mdl.size() < 64) mdl.push_back(8'(base + i));
            tick();
        end
        wr_en = 1'b0;
    endtask

    task automatic do_commit(input bit expect_start);
        commit = 1'b1;
        if (expect_start) push_expected();
        tick();
        commit = 1'b0;
        check("a_valid_after_commit", 32'(if_a.valid), 32'(expect_start));
        check("b_valid_after_commit", 32'(if_b.valid), 32'(expect_start));
        check("a_busy_after_commit",  32'(a_busy),     32'(expect_start));
    endtask

    task automatic do_flush();
        flush = 1'b1;
        tick();
        flush = 1'b0;
        mdl.delete();
        check("a_busy_after_flush", 32'(a_busy), 32'h0);
        check("b_busy_after_flush", 32'(b_busy), 32'h0);
    endtask

    task automatic drain(input bit rnd, input int budget);
        int n = 0;
        while ((sb_a.size() > 0 || sb_b.size() > 0) && n < budget) begin
            ready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
            tick();
            n++;
        end
        ready = 1'b0;
        if (sb_a.size() > 0 || sb_b.size() > 0) begin
            check("drain_timeout", 32'(sb_a.size() + sb_b.size()), 32'h0);
            sb_a.delete();
            sb_b.delete();
        end
    endtask

    // Monitor: sample away from the rising edge, pop on beats, check stability while stalled.
    initial begin
        exp_t        e;
        bit          stall_a = 1'b0, stall_b = 1'b0;
        logic [31:0] hold_a_d = 32'h0;
        logic [7:0]  hold_b_d = 8'h0;
        logic        hold_a_l = 1'b0, hold_b_l = 1'b0;
        forever begin
            @(negedge clk);
            if (rst && if_a.valid) begin
                if (stall_a) begin
                    check("a_stall_data", if_a.data, hold_a_d);
                    check("a_stall_last", 32'(if_a.last), 32'(hold_a_l));
                end
                if (if_a.ready) begin
                    if (sb_a.size() == 0) check("a_extra_beat", 32'h1, 32'h0);
                    else begin
                        e = sb_a.pop_front();
                        check("a_data",  if_a.data, e.data);
                        check("a_last",  32'(if_a.last), 32'(e.last));
                        check("a_bleft", 32'(a_bleft), 32'(e.bleft));
                    end
                end
            end
            if (rst && if_b.valid) begin
                if (stall_b) begin
                    check("b_stall_data", 32'(if_b.data), 32'(hold_b_d));
                    check("b_stall_last", 32'(if_b.last), 32'(hold_b_l));
                end
                if (if_b.ready) begin
                    if (sb_b.size() == 0) check("b_extra_beat", 32'h1, 32'h0);
                    else begin
                        e = sb_b.pop_front();
                        check("b_data",  32'(if_b.data), e.data);
                        check("b_last",  32'(if_b.last), 32'(e.last));
                        check("b_bleft", 32'(b_bleft), 32'(e.bleft));
                    end
                end
            end
            stall_a  = rst && if_a.valid && !if_a.ready;
            stall_b  = rst && if_b.valid && !if_b.ready;
            hold_a_d = if_a.data;
            hold_a_l = if_a.last;
            hold_b_d = if_b.data;
            hold_b_l = if_b.last;
        end
    end

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    initial begin
        repeat (3) tick();
        check("rst_a_valid", 32'(if_a.valid), 32'h0);
        check("rst_a_last",  32'(if_a.last),  32'h0);
        check("rst_a_busy",  32'(a_busy),     32'h0);
        check("rst_a_full",  32'(a_full),     32'h0);
        check("rst_a_ovf",   32'(a_ovf),      32'h0);
        check("rst_a_bleft", 32'(a_bleft),    32'h0);
        check("rst_b_valid", 32'(if_b.valid), 32'h0);
        rst = 1'b1;
        tick();

        // 40 bytes, sink always ready
        load_bytes(40, 0);
        do_commit(1'b1);
        drain(1'b0, 500);
        check("s1_a_done_busy",  32'(a_busy),     32'h1);
        check("s1_a_done_valid", 32'(if_a.valid), 32'h0);
        do_flush();

        // 6 bytes with padded tail, rewind replay, then a fresh segment
        load_bytes(6, 0);
        do_commit(1'b1);
        drain(1'b0, 100);
        rewind = 1'b1;
        push_expected();
        tick();
        rewind = 1'b0;
        check("s4_rewind_valid", 32'(if_a.valid), 32'h1);
        drain(1'b0, 100);
        do_flush();
        load_bytes(4, 8'hAA);
        do_commit(1'b1);
        drain(1'b0, 100);
        do_flush();

        // 40 bytes under random backpressure
        load_bytes(40, 0);
        do_commit(1'b1);
        drain(1'b1, 2000);
        do_flush();

        // Overflow: byte 65 is dropped
        load_bytes(64, 0);
        check("s5_a_full",     32'(a_full), 32'h1);
        check("s5_a_ovf_pre",  32'(a_ovf),  32'h0);
        load_bytes(1, 64);
        check("s5_a_ovf",      32'(a_ovf),  32'h1);
        check("s5_b_ovf",      32'(b_ovf),  32'h1);
        do_commit(1'b1);
        drain(1'b0, 500);
        check("s5_a_ovf_held", 32'(a_ovf),  32'h1);
        do_flush();
        check("s5_a_ovf_clr",  32'(a_ovf),  32'h0);
        check("s5_a_full_clr", 32'(a_full), 32'h0);

        // Flush in the cycle of beat 3
        load_bytes(40, 0);
        do_commit(1'b1);
        ready = 1'b1;
        tick();
        tick();
        flush = 1'b1;
        tick();
        flush = 1'b0;
        ready = 1'b0;
        check("s6_flush_a_valid", 32'(if_a.valid), 32'h0);
        check("s6_flush_b_valid", 32'(if_b.valid), 32'h0);
        check("s6_flush_a_sent",  32'(sb_a.size()), 32'd7);
        check("s6_flush_b_sent",  32'(sb_b.size()), 32'd37);
        sb_a.delete();
        sb_b.delete();
        mdl.delete();
        do_commit(1'b0);

        // Reset asserted before beat 3
        load_bytes(40, 0);
        do_commit(1'b1);
        ready = 1'b1;
        tick();
        tick();
        rst = 1'b0;
        #1;
        check("s6_rst_a_valid", 32'(if_a.valid), 32'h0);
        check("s6_rst_b_valid", 32'(if_b.valid), 32'h0);
        check("s6_rst_a_bleft", 32'(a_bleft),    32'h0);
        ready = 1'b0;
        sb_a.delete();
        sb_b.delete();
        mdl.delete();
        tick();
        rst = 1'b1;
        tick();
        do_commit(1'b0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
